ext_sram_mp: RTL and testbench

EXT_SRAM_MP -- requirements
Module: ext_sram_mp

---
 rtl/ext_sram_mp_pkg.sv | 16 +
 rtl/ext_sram_mp_rr_arbiter.sv | 36 +++
 rtl/ext_sram_mp.sv | 176 +++++++++++++++++
 tb/tb_ext_sram_mp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ext_sram_mp_pkg.sv
// Shared types and default parameter values for the ext_sram_mp memory model.
package ext_sram_mp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned NUM_RD_DEF = 2;
    localparam int unsigned RD_LAT_DEF = 4;
    localparam int unsigned WR_LAT_DEF = 4;

endpackage

// File: rtl/ext_sram_mp_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping to index 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Descending scan: the last hit in each half is the lowest index of that half.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (IDX_W'(i) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end else begin
                    w_lo_idx = IDX_W'(i);
                end
            end
        end
    end

    assign o_found = |i_req;
    assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/ext_sram_mp.sv
// Single-port SRAM shared by one writer and NUM_RD readers via round-robin arbitration.
// Optional per-byte write strobes when EXT_SRAM_MP_WSTRB_EN is defined.
module ext_sram_mp
    import ext_sram_mp_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned NUM_RD     = NUM_RD_DEF,
    parameter int unsigned RD_LATENCY = RD_LAT_DEF,
    parameter int unsigned WR_LATENCY = WR_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
`ifdef EXT_SRAM_MP_WSTRB_EN
    input  logic [DATA_W/8-1:0]      w_strb,
`endif
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    input  logic [NUM_RD-1:0]        r_valid,
    output logic [NUM_RD-1:0]        r_ready,
    output logic [NUM_RD*DATA_W-1:0] r_data
);

    localparam int unsigned NUM_REQ = NUM_RD + 1;
    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned CNT_W   = 16;

    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_ptr;
    logic [IDX_W-1:0]         r_gnt_idx;
    logic [ADDR_W-1:0]        r_lat_addr;
    logic [DATA_W-1:0]        r_lat_data;
    logic                     r_wready;
    logic [NUM_RD-1:0]        r_rready;
    logic [NUM_RD*DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0]        r_mem [DEPTH];

    logic [NUM_REQ-1:0]       w_req;
    logic                     w_arb_found;
    logic [IDX_W-1:0]         w_arb_idx;
    logic [IDX_W-1:0]         w_next_ptr;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [CNT_W-1:0]         w_lat_m1;
    logic                     w_gnt_valid;
    logic                     w_commit;
    logic [DATA_W-1:0]        w_mem_wdata;

    // Requester 0 is the writer, 1..NUM_RD are the read channels.
    assign w_req = {r_valid, w_valid};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_found (w_arb_found),
        .o_idx   (w_arb_idx)
    );

    assign w_next_ptr = (w_arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;

    always_comb begin
        w_sel_addr = w_addr;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_arb_idx == IDX_W'(i + 1)) begin
                w_sel_addr = r_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt_idx == IDX_W'(i)) begin
                w_gnt_valid = w_req[i];
            end
        end
    end

    assign w_lat_m1 = (r_gnt_idx == '0) ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
    assign w_commit = (r_state == StBusy) && w_gnt_valid && (r_cnt == w_lat_m1);

`ifdef EXT_SRAM_MP_WSTRB_EN
    logic [DATA_W/8-1:0] r_lat_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_strb <= '0;
        end else if (r_state == StIdle && w_arb_found) begin
            r_lat_strb <= w_strb;
        end
    end

    // Read-modify-write: unstrobed bytes keep the current memory contents.
    always_comb begin
        w_mem_wdata = r_mem[r_lat_addr];
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (r_lat_strb[b]) begin
                w_mem_wdata[b*8 +: 8] = r_lat_data[b*8 +: 8];
            end
        end
    end
`else
    assign w_mem_wdata = r_lat_data;
`endif

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && r_gnt_idx == '0) begin
            r_mem[r_lat_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_lat_addr <= '0;
            r_lat_data <= '0;
            r_wready   <= 1'b0;
            r_rready   <= '0;
            r_rdata    <= '0;
        end else begin
            r_wready <= 1'b0;
            r_rready <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_arb_found) begin
                        r_gnt_idx  <= w_arb_idx;
                        r_lat_addr <= w_sel_addr;
                        r_lat_data <= w_data;
                        r_cnt      <= '0;
                        r_ptr      <= w_next_ptr;
                        r_state    <= StBusy;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_gnt_valid) begin
                        r_state <= StIdle;
                    end else if (w_commit) begin
                        r_state <= StDone;
                        if (r_gnt_idx == '0) begin
                            r_wready <= 1'b1;
                        end
                        for (int i = 0; i < NUM_RD; i++) begin
                            if (r_gnt_idx == IDX_W'(i + 1)) begin
                                r_rready[i]                <= 1'b1;
                                r_rdata[i*DATA_W +: DATA_W] <= r_mem[r_lat_addr];
                            end
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_ready = r_wready;
    assign r_ready = r_rready;
    assign r_data  = r_rdata;

endmodule

// File: tb/tb_ext_sram_mp.sv
// Directed self-checking bench for ext_sram_mp (default parameters).
module tb_ext_sram_mp;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int NR  = 2;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    w_addr = '0;
    logic [DW-1:0]    w_data = '0;
    logic             w_valid = 1'b0;
    logic             w_ready;
    logic [NR*AW-1:0] r_addr = '0;
    logic [NR-1:0]    r_valid = '0;
    logic [NR-1:0]    r_ready;
    logic [NR*DW-1:0] r_data;
`ifdef EXT_SRAM_MP_WSTRB_EN
    logic [DW/8-1:0]  w_strb = '1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ext_sram_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_addr  (w_addr),
        .w_data  (w_data),
`ifdef EXT_SRAM_MP_WSTRB_EN
        .w_strb  (w_strb),
`endif
        .w_valid (w_valid),
        .w_ready (w_ready),
        .r_addr  (r_addr),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        w_valid = 1'b0;
        r_valid = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Ready is expected on the LAT+1-th edge counted from the request (edge 1 = grant).
    task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k_rdy;
        k_rdy   = 0;
        w_addr  = a;
        w_data  = d;
        w_valid = 1'b1;
        for (int k = 1; k <= 30 && k_rdy == 0; k++) begin
            tick();
            if (w_ready) k_rdy = k;
        end
        w_valid = 1'b0;
        check({tag, " w_lat"}, 64'(k_rdy), 64'(LAT + 1));
        tick();
        check({tag, " w_pulse"}, 64'(w_ready), 64'd0);
    endtask

    task automatic do_read(input string tag, input int ch, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp_d);
        int k_rdy;
        k_rdy = 0;
        r_addr[ch*AW +: AW] = a;
        r_valid[ch] = 1'b1;
        for (int k = 1; k <= 30 && k_rdy == 0; k++) begin
            tick();
            if (r_ready[ch]) k_rdy = k;
        end
        r_valid[ch] = 1'b0;
        check({tag, " r_lat"}, 64'(k_rdy), 64'(LAT + 1));
        check({tag, " r_data"}, 64'(r_data[ch*DW +: DW]), 64'(exp_d));
        tick();
        check({tag, " r_pulse"}, 64'(r_ready[ch]), 64'd0);
        check({tag, " r_hold"}, 64'(r_data[ch*DW +: DW]), 64'(exp_d));
    endtask

    initial begin
        int kw, k0, k1, seen1;
        logic [DW-1:0] d0, d1;

        reset_dut();
        check("rst w_ready", 64'(w_ready), 64'd0);
        check("rst r_ready", 64'(r_ready), 64'd0);
        check("rst r_data", 64'(r_data), 64'd0);

        do_write("wr5", 10'd5, 32'hDEADBEEF);
        do_read("rd5 ch0", 0, 10'd5, 32'hDEADBEEF);

        // Simultaneous requests: write, ch0, ch1 served in order, period LAT+2.
        reset_dut();
        w_addr  = 10'd9;
        w_data  = 32'h12345678;
        w_valid = 1'b1;
        r_addr  = {10'd9, 10'd9};
        r_valid = 2'b11;
        kw = 0; k0 = 0; k1 = 0; d0 = '0; d1 = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (w_ready && kw == 0) begin kw = k; w_valid = 1'b0; end
            if (r_ready[0] && k0 == 0) begin k0 = k; r_valid[0] = 1'b0; d0 = r_data[DW-1:0]; end
            if (r_ready[1] && k1 == 0) begin k1 = k; r_valid[1] = 1'b0; d1 = r_data[2*DW-1:DW]; end
        end
        check("rr write lat", 64'(kw), 64'(LAT + 1));
        check("rr ch0 lat", 64'(k0), 64'(2 * LAT + 3));
        check("rr ch1 lat", 64'(k1), 64'(3 * LAT + 5));
        check("rr ch0 data", 64'(d0), 64'h12345678);
        check("rr ch1 data", 64'(d1), 64'h12345678);

        // Abort: ch1 drops valid two cycles into BUSY; ch0 request raised at the same time.
        do_write("wr3", 10'd3, 32'hCAFEF00D);
        r_addr[AW +: AW] = 10'd3;
        r_valid[1] = 1'b1;
        tick();
        tick();
        tick();
        r_valid[1] = 1'b0;
        r_addr[0 +: AW] = 10'd3;
        r_valid[0] = 1'b1;
        k0 = 0; seen1 = 0; d0 = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (r_ready[1]) seen1 = 1;
            if (r_ready[0] && k0 == 0) begin k0 = k; r_valid[0] = 1'b0; d0 = r_data[DW-1:0]; end
        end
        check("abort no ready1", 64'(seen1), 64'd0);
        check("abort ch1 held", 64'(r_data[2*DW-1:DW]), 64'h12345678);
        check("abort ch0 lat", 64'(k0), 64'(LAT + 2));
        check("abort ch0 data", 64'(d0), 64'hCAFEF00D);

        // Reset mid-write to addr 7 must discard the write.
        do_write("wr7", 10'd7, 32'h77777777);
        w_addr  = 10'd7;
        w_data  = 32'hFFFF0000;
        w_valid = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst w_ready", 64'(w_ready), 64'd0);
        check("midrst r_ready", 64'(r_ready), 64'd0);
        check("midrst r_data", 64'(r_data), 64'd0);
        w_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        do_read("rd7 ch1", 1, 10'd7, 32'h77777777);

`ifdef EXT_SRAM_MP_WSTRB_EN
        w_strb = 4'hF;
        do_write("wr20 full", 10'd20, 32'h11223344);
        w_strb = 4'b0101;
        do_write("wr20 strb", 10'd20, 32'hAABBCCDD);
        w_strb = 4'hF;
        do_read("rd20 ch0", 0, 10'd20, 32'h11BB33DD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
